// File: rtl/rv32m_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// rv32m_muldiv_unit_if
// Request/response bundle between the core (master) and the iterative RV32M
// multiply/divide unit (slave).
//   i_start     request, taken only while o_ready is high
//   i_funct3    M-extension funct3 (MUL..REMU)
//   i_rs1_data  operand A (multiplicand / dividend)
//   i_rs2_data  operand B (multiplier / divisor)
//   i_flush     abort the operation in flight
//   o_ready     unit idle
//   o_busy      operation in flight or completing (core stall)
//   o_done      one-cycle pulse, o_result valid
//   o_result    result for rd writeback, held until the next completion
// ---------------------------------------------------------------------------
interface rv32m_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_start;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic            i_flush;
  logic            o_ready;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_funct3, i_rs1_data, i_rs2_data, i_flush,
    input  o_ready, o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_funct3, i_rs1_data, i_rs2_data, i_flush,
    output o_ready, o_busy, o_done, o_result
  );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// ---------------------------------------------------------------------------
// rv32m_muldiv_unit
// Iterative RV32M multiply/divide unit. Operands are converted to magnitudes
// on acceptance, then a shift-add multiplier and a restoring divider each
// retire one bit per cycle for XLEN cycles. The sign-corrected result is
// registered on the last iteration and flagged by a one-cycle o_done pulse.
// Divide-by-zero and signed overflow resolve immediately on acceptance.
//   i_clk   clock, rising edge
//   i_rst   asynchronous, active-high reset
//   bus     rv32m_muldiv_unit_if slave modport (request / response)
// ---------------------------------------------------------------------------
module rv32m_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic                i_clk,
  input logic                i_rst,
  rv32m_muldiv_unit_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   a_q, a_d;       // multiplicand magnitude
  logic [XLEN-1:0]   b_q, b_d;       // divisor magnitude
  logic [2*XLEN-1:0] prod_q, prod_d; // upper: partial sum, lower: multiplier bits left
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;   // dividend bits shift out as quotient bits shift in
  logic              neg_q, neg_d;   // negate product / quotient
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // ---------------------------------------------------------------------
  // Acceptance-time decode
  // ---------------------------------------------------------------------
  logic [2:0]      f3_in;
  logic            sign_a_en, sign_b_en;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            is_div_in, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign f3_in     = bus.i_funct3;
  assign sign_a_en = (f3_in == 3'd1) || (f3_in == 3'd2) || (f3_in == 3'd4) || (f3_in == 3'd6);
  assign sign_b_en = (f3_in == 3'd1) || (f3_in == 3'd4) || (f3_in == 3'd6);
  assign a_neg     = sign_a_en && bus.i_rs1_data[XLEN-1];
  assign b_neg     = sign_b_en && bus.i_rs2_data[XLEN-1];
  assign a_abs     = a_neg ? (-bus.i_rs1_data) : bus.i_rs1_data;
  assign b_abs     = b_neg ? (-bus.i_rs2_data) : bus.i_rs2_data;

  assign is_div_in = f3_in[2];
  assign div_zero  = is_div_in && (bus.i_rs2_data == '0);
  // Only signed DIV/REM (funct3[0] == 0) can overflow.
  assign div_ovf   = is_div_in && !f3_in[0] && (bus.i_rs1_data == MinNeg) &&
                     (bus.i_rs2_data == AllOnes);
  assign special   = div_zero || div_ovf;

  always_comb begin
    if (div_zero) begin
      special_res = f3_in[1] ? bus.i_rs1_data : AllOnes;
    end else begin
      special_res = f3_in[1] ? '0 : bus.i_rs1_data;
    end
  end

  // ---------------------------------------------------------------------
  // One iteration of each datapath
  // ---------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;  // XLEN+1-bit partial remainder
  logic              div_ok;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   rem_next, quo_next;

  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
  assign mul_next = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};

  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_ok    = (div_shift >= {1'b0, b_q});
  // The difference is below b_q whenever it is kept, so XLEN bits suffice.
  assign div_diff  = div_shift[XLEN-1:0] - b_q;
  assign rem_next  = div_ok ? div_diff : div_shift[XLEN-1:0];
  assign quo_next  = {quo_q[XLEN-2:0], div_ok};

  // Sign-corrected result from the final iteration values.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  assign prod_fix = neg_q ? (-mul_next) : mul_next;
  assign quo_fix  = neg_q ? (-quo_next) : quo_next;
  assign rem_fix  = rem_neg_q ? (-rem_next) : rem_next;

  always_comb begin
    if (funct3_q[2]) begin
      calc_res = funct3_q[1] ? rem_fix : quo_fix;
    end else if (funct3_q[1:0] == 2'd0) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        // Flush wins over a simultaneous request.
        if (bus.i_start && !bus.i_flush) begin
          funct3_d  = f3_in;
          a_d       = a_abs;
          b_d       = b_abs;
          prod_d    = {{XLEN{1'b0}}, b_abs};
          rem_d     = '0;
          quo_d     = a_abs;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          if (special) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end

      StCalc: begin
        if (bus.i_flush) begin
          state_d = StIdle;
        end else begin
          prod_d = mul_next;
          rem_d  = rem_next;
          quo_d  = quo_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            result_d = calc_res;
            state_d  = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      funct3_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  assign bus.o_ready  = (state_q == StIdle);
  assign bus.o_busy   = (state_q == StCalc) || (state_q == StDone);
  assign bus.o_done   = (state_q == StDone);
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
module tb_rv32m_muldiv_unit;

  logic clk = 1'b0;
  logic rst;

  rv32m_muldiv_unit_if #(.XLEN(32)) bus ();

  rv32m_muldiv_unit #(
    .XLEN (32),
    .CNT_W(6)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result = 32'h0;

  // Reference model: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'h0;
    case (f3)
      3'd0: p = 64'(sa * sb);
      3'd1: p = 64'(sa * sb) >> 32;
      3'd2: p = 64'(sa * longint'({32'h0, b})) >> 32;
      3'd3: p = ({32'h0, a} * {32'h0, b}) >> 32;
      3'd4: begin
        if (b == 32'h0) p = 64'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
        else p = 64'(sa / sb);
      end
      3'd5: begin
        if (b == 32'h0) p = 64'hFFFF_FFFF;
        else p = {32'h0, a / b};
      end
      3'd6: begin
        if (b == 32'h0) p = {32'h0, a};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h0;
        else p = 64'(sa % sb);
      end
      default: begin
        if (b == 32'h0) p = {32'h0, a};
        else p = {32'h0, a % b};
      end
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 32'h0) ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one operation from IDLE (called at #1 after a rising edge). Latency is
  // counted in edges including the accepting one: 33 normally, 1 for specials.
  // With scramble set, i_start stays high and operands change every cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input string name);
    logic [31:0] expv;
    int exp_lat, edges;
    bit seen;
    expv    = ref_model(f3, a, b);
    exp_lat = is_special(f3, a, b) ? 1 : 33;
    bus.i_funct3   = f3;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_start    = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (scramble) begin
        bus.i_rs1_data = $urandom;
        bus.i_rs2_data = $urandom;
        bus.i_funct3   = 3'($urandom_range(0, 7));
      end else begin
        bus.i_start = 1'b0;
      end
      if (edges == 1) begin
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s accept: busy=%b ready=%b, required busy=1 ready=0",
                   name, bus.o_busy, bus.o_ready);
        end
      end
      if (bus.o_done === 1'b1) seen = 1'b1;
    end
    bus.i_start = 1'b0;
    checks++;
    if (!seen || edges != exp_lat) begin
      errors++;
      $display("FAIL %s latency: done_seen=%b edges=%0d, required %0d", name, seen, edges,
               exp_lat);
    end
    checks++;
    if (bus.o_result !== expv) begin
      errors++;
      $display("FAIL %s result: got %h, required %h (f3=%0d a=%h b=%h)", name, bus.o_result,
               expv, f3, a, b);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s pulse: done=%b ready=%b one cycle later, required done=0 ready=1",
               name, bus.o_done, bus.o_ready);
    end
    last_result = expv;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_funct3   = 3'd0;
    bus.i_rs1_data = 32'h0;
    bus.i_rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
        bus.o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b done=%b result=%h, required 1 0 0 00000000",
               bus.o_ready, bus.o_busy, bus.o_done, bus.o_result);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, "mul_7x-3");
    run_op(3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, "mulh_7x-3");
    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, "mulhu_7x-3");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_-1xff");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min_min");
  endtask

  task automatic test_div();
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, 1'b0, "divu_100/7");
    run_op(3'd7, 32'd100, 32'd7, 1'b0, "remu_100/7");
  endtask

  task automatic test_special();
    run_op(3'd4, 32'd5, 32'd0, 1'b0, "div_5/0");
    run_op(3'd7, 32'd5, 32'd0, 1'b0, "remu_5/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(f3, a, b, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, "b2b_mul_held");
    run_op(3'd5, 32'd100, 32'd7, 1'b1, "b2b_divu_held");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "b2b_rem");
  endtask

  task automatic test_flush();
    int pulses;
    bus.i_funct3   = 3'd3;
    bus.i_rs1_data = $urandom;
    bus.i_rs2_data = $urandom;
    bus.i_start    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
        bus.o_result !== last_result) begin
      errors++;
      $display("FAIL flush_calc: ready=%b busy=%b done=%b result=%h, required 1 0 0 %h",
               bus.o_ready, bus.o_busy, bus.o_done, bus.o_result, last_result);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_no_done: %0d done pulses after flush, required 0", pulses);
    end
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 1'b0, "after_flush_div");

    // Flush and start together in IDLE: the request must not be taken.
    bus.i_funct3   = 3'd0;
    bus.i_rs1_data = 32'd3;
    bus.i_rs2_data = 32'd5;
    bus.i_start    = 1'b1;
    bus.i_flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%b busy=%b, required ready=1 busy=0", bus.o_ready,
               bus.o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bus.i_funct3   = 3'd0;
    bus.i_rs1_data = 32'd3;
    bus.i_rs2_data = 32'd5;
    bus.i_start    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
        bus.o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b busy=%b done=%b result=%h, required 1 0 0 00000000",
               bus.o_ready, bus.o_busy, bus.o_done, bus.o_result);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: pulses=%0d ready=%b, required 0 and 1", pulses,
               bus.o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
